pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl_if.sv | 21 ++
 rtl/pc_fetch_ctrl.sv | 96 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-request handshake between the PC controller and instruction memory.
// The controller drives request valid and address; memory drives ready.
interface pc_fetch_ctrl_if #(
    parameter int unsigned N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] pc_q;

    modport master (
        output req_valid,
        output pc_q,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  pc_q,
        output req_ready
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request controller: drives the next-PC mux select,
// holds the fetch PC and buffers redirects that arrive during an unaccepted request.
module pc_fetch_ctrl #(
    parameter int unsigned   N        = 32,
    parameter logic [N-1:0]  RESET_PC = '0,
    parameter int unsigned   INC      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      pc_next,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              trap,
    input  logic              stall,
    output logic [1:0]        pc_sel,
    output logic [N-1:0]      pc_plus,
    output logic              misalign,
    pc_fetch_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_r, pc_d;
    logic [N-1:0] pend_pc, pend_pc_d;
    logic         pend_valid, pend_valid_d;
    logic         redir;
    logic         handshake;

    assign redir     = trap | jump | branch_taken;
    assign pc_plus   = pc_r + N'(INC);
    assign handshake = (state_q == REQ) && bus.req_ready;

    // req_valid decodes straight from state so an async reset drops it at once
    assign bus.req_valid = (state_q == REQ);
    assign bus.pc_q      = pc_r;

    always_comb begin
        if (trap)              pc_sel = 2'b11;
        else if (jump)         pc_sel = 2'b10;
        else if (branch_taken) pc_sel = 2'b01;
        else                   pc_sel = 2'b00;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_r;
        pend_pc_d    = pend_pc;
        pend_valid_d = pend_valid;
        case (state_q)
            IDLE: begin
                if (redir) pc_d = pc_next;
                state_d = stall ? STALL : REQ;
            end
            REQ: begin
                if (handshake) begin
                    if (redir)           pc_d = pc_next;
                    else if (pend_valid) pc_d = pend_pc;
                    else                 pc_d = pc_plus;
                    pend_valid_d = 1'b0;
                    state_d      = stall ? STALL : REQ;
                end else if (redir) begin
                    // newest redirect wins; applied once this request is accepted
                    pend_pc_d    = pc_next;
                    pend_valid_d = 1'b1;
                end
            end
            STALL: begin
                if (redir) pc_d = pc_next;
                if (!stall) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_r       <= RESET_PC;
            pend_pc    <= '0;
            pend_valid <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_r       <= pc_d;
            pend_pc    <= pend_pc_d;
            pend_valid <= pend_valid_d;
            misalign   <= redir && (pc_next[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized checks of pc_fetch_ctrl against a cycle-level reference model.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_next;
    logic        branch_taken, jump, trap, stall;
    logic [1:0]  pc_sel;
    logic [31:0] pc_plus;
    logic        misalign;

    int unsigned tests;
    int unsigned fails;

    // reference model: request presented or not, fetch PC, one pending redirect
    logic        m_offer;
    logic [31:0] m_pc;
    logic        m_pend_v;
    logic [31:0] m_pend;
    logic        m_mis;

    pc_fetch_ctrl_if #(.N(32)) bus ();

    pc_fetch_ctrl #(.N(32), .RESET_PC(32'h0), .INC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_next      (pc_next),
        .branch_taken (branch_taken),
        .jump         (jump),
        .trap         (trap),
        .stall        (stall),
        .pc_sel       (pc_sel),
        .pc_plus      (pc_plus),
        .misalign     (misalign),
        .bus          (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_offer  = 1'b0;
        m_pc     = 32'h0;
        m_pend_v = 1'b0;
        m_pend   = 32'h0;
        m_mis    = 1'b0;
    endtask

    // One clock: drive inputs, check outputs against the model, clock, advance the model.
    task automatic step(input logic br, input logic jp, input logic tp, input logic st,
                        input logic rdy, input logic [31:0] tgt);
        logic        rd;
        logic [1:0]  esel;
        rd = br | jp | tp;
        esel = tp ? 2'd3 : jp ? 2'd2 : br ? 2'd1 : 2'd0;
        branch_taken  = br;
        jump          = jp;
        trap          = tp;
        stall         = st;
        bus.req_ready = rdy;
        pc_next       = rd ? tgt : m_pc + 32'd4;
        #1;
        chk("req_valid", {31'b0, bus.req_valid}, {31'b0, m_offer});
        chk("pc_q",      bus.pc_q, m_pc);
        chk("pc_plus",   pc_plus, m_pc + 32'd4);
        chk("pc_sel",    {30'b0, pc_sel}, {30'b0, esel});
        chk("misalign",  {31'b0, misalign}, {31'b0, m_mis});
        @(posedge clk);
        m_mis = rd && (tgt[1:0] != 2'b00);
        if (m_offer && rdy) begin
            m_pc     = rd ? tgt : m_pend_v ? m_pend : m_pc + 32'd4;
            m_pend_v = 1'b0;
            m_offer  = !st;
        end else if (m_offer) begin
            if (rd) begin
                m_pend   = tgt;
                m_pend_v = 1'b1;
            end
        end else begin
            if (rd) m_pc = tgt;
            m_offer = !st;
        end
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; trap = 1'b0; stall = 1'b0;
        bus.req_ready = 1'b1;
        pc_next = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, bus.req_valid}, 32'd0);
        chk("rst_pc", bus.pc_q, 32'h0);
        chk("rst_mis", {31'b0, misalign}, 32'd0);
        rst_n = 1'b1;

        // reset exit and sequential fetch
        repeat (3) step(0, 0, 0, 0, 1, 32'h0);
        chk("seq_pc", bus.pc_q, 32'h8);
        // backpressure holds request
        repeat (3) step(0, 0, 0, 0, 0, 32'h0);
        chk("bp_pc", bus.pc_q, 32'h8);
        step(0, 0, 0, 0, 1, 32'h0);
        chk("bp_after", bus.pc_q, 32'hC);
        // buffered jump
        step(0, 0, 0, 0, 1, 32'h0);
        chk("buf_start", bus.pc_q, 32'h10);
        step(0, 1, 0, 0, 0, 32'h200);
        chk("buf_hold", bus.pc_q, 32'h10);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0);
        chk("buf_apply", bus.pc_q, 32'h200);
        step(0, 0, 0, 0, 1, 32'h0);
        chk("buf_next", bus.pc_q, 32'h204);
        // simultaneous redirects
        step(1, 1, 1, 0, 1, 32'h80);
        chk("prio_pc", bus.pc_q, 32'h80);
        // stall and misaligned branch
        step(0, 1, 0, 0, 1, 32'h1C);
        step(0, 0, 0, 0, 1, 32'h0);
        chk("stall_pre", bus.pc_q, 32'h20);
        step(0, 0, 0, 1, 1, 32'h0);
        chk("stall_valid", {31'b0, bus.req_valid}, 32'd0);
        step(1, 0, 0, 1, 1, 32'h102);
        chk("stall_redir", bus.pc_q, 32'h102);
        chk("mis_pulse", {31'b0, misalign}, 32'd1);
        step(0, 0, 0, 1, 1, 32'h0);
        chk("mis_clear", {31'b0, misalign}, 32'd0);
        step(0, 0, 0, 0, 1, 32'h0);
        chk("unstall_valid", {31'b0, bus.req_valid}, 32'd1);
        chk("unstall_pc", bus.pc_q, 32'h102);
        // wrap-around
        step(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1, 32'h0);
        chk("wrap_pc", bus.pc_q, 32'h0);
        // async reset during an unaccepted request
        step(0, 0, 0, 0, 1, 32'h0);
        step(0, 1, 0, 0, 0, 32'h300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", {31'b0, bus.req_valid}, 32'd0);
        chk("areset_pc", bus.pc_q, 32'h0);
        model_reset();
        rst_n = 1'b1;
        // pending redirect must have been discarded
        step(0, 0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 0, 1, 32'h0);
        chk("areset_nopend", bus.pc_q, 32'h4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0, t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
